lsu: RTL and testbench

- Load/store unit between the execute stage and the DPI-backed data memory port (mem_raddr/mem_read/mem_waddr/mem_wdata/mem_wmask/mem_write/mem_rdata).
- Accepts one RV64 load or store per transaction over a valid/ready handshake.
- Drives exactly one single-cycle, 8-byte-aligned memory access, then returns the aligned and sign/zero-extended load result over a second valid/ready handshake.
- Misaligned or illegal requests are rejected without touching memory.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_if.sv | 47 ++++
 rtl/lsu_align.sv | 54 +++++
 rtl/lsu.sv | 164 ++++++++++++++++
 tb/tb_lsu.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit.
// funct3 codes, FSM states and byte-enable size masks.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic [7:0] size_mask(
    input logic [1:0] sz
  );
    logic [7:0] m;
    unique case (sz)
      2'd0:    m = MASK_B;
      2'd1:    m = MASK_H;
      2'd2:    m = MASK_W;
      default: m = MASK_D;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshakes and memory port of the LSU.
// slave = LSU side, master = execute stage plus memory model.
interface lsu_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic            req_wen;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic [XLEN-1:0] mem_raddr;
  logic            mem_read;
  logic [XLEN-1:0] mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic [7:0]      mem_wmask;
  logic            mem_write;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_wen, req_funct3,
    input  req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_raddr, mem_read,
    output mem_waddr, mem_wdata,
    output mem_wmask, mem_write,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_wen, req_funct3,
    output req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_raddr, mem_read,
    input  mem_waddr, mem_wdata,
    input  mem_wmask, mem_write,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment, load extension and legality check.
// Purely combinational; the FSM in lsu decides when it is used.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        wen,
  input  logic [2:0]  funct3,
  input  logic [2:0]  off,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  wmask,
  output logic [63:0] wdata_sh,
  output logic [63:0] ldata,
  output logic        err
);

  logic [1:0]  sz;
  logic [5:0]  sh_amt;
  logic [63:0] rsh;
  logic        illegal;
  logic        misal;

  assign sz       = funct3[1:0];
  assign sh_amt   = {off, 3'b000};
  assign wmask    = size_mask(sz) << off;
  assign wdata_sh = wdata << sh_amt;
  assign rsh      = rdata >> sh_amt;

  always_comb begin
    illegal = wen ? funct3[2] : (funct3 == 3'b111);
    unique case (sz)
      2'd0:    misal = 1'b0;
      2'd1:    misal = off[0];
      2'd2:    misal = |off[1:0];
      default: misal = |off;
    endcase
    err = illegal | misal;
  end

  always_comb begin
    ldata = 64'd0;
    case (funct3)
      LB:  ldata = {{56{rsh[7]}}, rsh[7:0]};
      LH:  ldata = {{48{rsh[15]}}, rsh[15:0]};
      LW:  ldata = {{32{rsh[31]}}, rsh[31:0]};
      LD:  ldata = rsh;
      LBU: ldata = {56'd0, rsh[7:0]};
      LHU: ldata = {48'd0, rsh[15:0]};
      LWU: ldata = {32'd0, rsh[31:0]};
      default: ldata = 64'd0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one aligned single-cycle memory access per request.
// IDLE -> ACCESS -> RESP, or IDLE -> RESP for rejected requests.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);

  state_e          state_q, state_d;
  logic            wen_q, wen_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [2:0]      off_q, off_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;
  logic [XLEN-1:0] mem_raddr_q, mem_raddr_d;
  logic            mem_read_q, mem_read_d;
  logic [XLEN-1:0] mem_waddr_q, mem_waddr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]      mem_wmask_q, mem_wmask_d;
  logic            mem_write_q, mem_write_d;

  logic            idle;
  logic            al_wen;
  logic [2:0]      al_f3;
  logic [2:0]      al_off;
  logic [7:0]      al_wmask;
  logic [63:0]     al_wdata;
  logic [63:0]     al_ldata;
  logic            al_err;
  logic [XLEN-1:0] base;

  // Aligner sees live request in IDLE, captured fields afterwards.
  assign idle   = (state_q == IDLE);
  assign al_wen = idle ? bus.req_wen : wen_q;
  assign al_f3  = idle ? bus.req_funct3 : funct3_q;
  assign al_off = idle ? bus.req_addr[2:0] : off_q;
  assign base   = {bus.req_addr[XLEN-1:3], 3'b000};

  lsu_align u_align (
    .wen      (al_wen),
    .funct3   (al_f3),
    .off      (al_off),
    .wdata    (bus.req_wdata),
    .rdata    (bus.mem_rdata),
    .wmask    (al_wmask),
    .wdata_sh (al_wdata),
    .ldata    (al_ldata),
    .err      (al_err)
  );

  always_comb begin
    state_d      = state_q;
    wen_d        = wen_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_raddr_d  = '0;
    mem_read_d   = 1'b0;
    mem_waddr_d  = '0;
    mem_wdata_d  = '0;
    mem_wmask_d  = 8'd0;
    mem_write_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wen_d       = bus.req_wen;
          funct3_d    = bus.req_funct3;
          off_d       = bus.req_addr[2:0];
          req_ready_d = 1'b0;
          if (al_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d    = ACCESS;
            resp_err_d = 1'b0;
            if (bus.req_wen) begin
              mem_write_d = 1'b1;
              mem_waddr_d = base;
              mem_wmask_d = al_wmask;
              mem_wdata_d = al_wdata;
            end else begin
              mem_read_d  = 1'b1;
              mem_raddr_d = base;
            end
          end
        end
      end
      ACCESS: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = wen_q ? '0 : al_ldata;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wen_q        <= 1'b0;
      funct3_q     <= 3'd0;
      off_q        <= 3'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_raddr_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= 8'd0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wen_q        <= wen_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_raddr_q  <= mem_raddr_d;
      mem_read_q   <= mem_read_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_raddr  = mem_raddr_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_waddr  = mem_waddr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wmask  = mem_wmask_q;
  assign bus.mem_write  = mem_write_q;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu.
// Inputs change on negedge; outputs sampled 1ns after posedge.
module tb_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  lsu_if bus();

  lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic send(
    input logic        wen,
    input logic [2:0]  f3,
    input logic [63:0] addr,
    input logic [63:0] wdata,
    input logic [63:0] rdata
  );
    @(negedge clk);
    bus.req_wen    = wen;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.mem_rdata  = rdata;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic release_resp();
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 64'd0;
    bus.req_wdata  = 64'd0;
    bus.resp_ready = 1'b0;
    bus.mem_rdata  = 64'd0;
    rst = 1'b1;
    #12;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs ready=%b valid=%b want 1 0",
               bus.req_ready, bus.resp_valid);
    end
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 ||
        bus.mem_wmask !== 8'd0 || bus.resp_rdata !== 64'd0 ||
        bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_out rd=%b wr=%b mask=%h rdata=%h err=%b want 0",
               bus.mem_read, bus.mem_write, bus.mem_wmask,
               bus.resp_rdata, bus.resp_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ld();
    send(1'b0, LD, 64'h8000_0010, 64'd0, 64'h1122334455667788);
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_raddr !== 64'h8000_0010 ||
        bus.mem_write !== 1'b0) begin
      errors++;
      $display("FAIL ld_access rd=%b addr=%h wr=%b want 1 80000010 0",
               bus.mem_read, bus.mem_raddr, bus.mem_write);
    end
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ld_latency valid=%b ready=%b want 0 0",
               bus.resp_valid, bus.req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.resp_valid !== 1'b1 ||
        bus.resp_rdata !== 64'h1122334455667788 ||
        bus.resp_err !== 1'b0 || bus.mem_read !== 1'b0) begin
      errors++;
      $display("FAIL ld_resp v=%b d=%h e=%b rd=%b want 1 1122334455667788 0 0",
               bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.mem_read);
    end
    release_resp();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL ld_idle ready=%b valid=%b want 1 0",
               bus.req_ready, bus.resp_valid);
    end
  endtask

  task automatic test_lb_lbu();
    send(1'b0, LB, 64'h8000_0005, 64'd0, 64'h0000_9A00_0000_0000);
    checks++;
    if (bus.mem_raddr !== 64'h8000_0000 || bus.mem_read !== 1'b1) begin
      errors++;
      $display("FAIL lb_addr addr=%h rd=%b want 80000000 1",
               bus.mem_raddr, bus.mem_read);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.resp_rdata !== 64'hFFFF_FFFF_FFFF_FF9A) begin
      errors++;
      $display("FAIL lb_data got=%h want ffffffffffffff9a",
               bus.resp_rdata);
    end
    release_resp();
    send(1'b0, LBU, 64'h8000_0005, 64'd0, 64'h0000_9A00_0000_0000);
    @(posedge clk);
    #1;
    checks++;
    if (bus.resp_rdata !== 64'h9A || bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL lbu_data got=%h err=%b want 9a 0",
               bus.resp_rdata, bus.resp_err);
    end
    release_resp();
  endtask

  task automatic test_lh_lw();
    send(1'b0, LH, 64'h8000_0002, 64'd0, 64'h0000_0000_8001_0000);
    @(posedge clk);
    #1;
    checks++;
    if (bus.resp_rdata !== 64'hFFFF_FFFF_FFFF_8001) begin
      errors++;
      $display("FAIL lh_data got=%h want ffffffffffff8001",
               bus.resp_rdata);
    end
    release_resp();
    send(1'b0, LWU, 64'h8000_0004, 64'd0, 64'hF234_5678_0000_0000);
    @(posedge clk);
    #1;
    checks++;
    if (bus.resp_rdata !== 64'h0000_0000_F234_5678) begin
      errors++;
      $display("FAIL lwu_data got=%h want 00000000f2345678",
               bus.resp_rdata);
    end
    release_resp();
  endtask

  task automatic test_sh();
    send(1'b1, SH, 64'h8000_0106, 64'hABCD, 64'd0);
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_waddr !== 64'h8000_0100 ||
        bus.mem_wmask !== 8'hC0 ||
        bus.mem_wdata !== 64'hABCD_0000_0000_0000 ||
        bus.mem_read !== 1'b0) begin
      errors++;
      $display("FAIL sh_access wr=%b a=%h m=%h d=%h rd=%b want 1 80000100 c0 abcd000000000000 0",
               bus.mem_write, bus.mem_waddr, bus.mem_wmask,
               bus.mem_wdata, bus.mem_read);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.mem_write !== 1'b0 || bus.mem_wmask !== 8'd0 ||
        bus.resp_valid !== 1'b1 || bus.resp_rdata !== 64'd0 ||
        bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL sh_resp wr=%b m=%h v=%b d=%h e=%b want 0 00 1 0 0",
               bus.mem_write, bus.mem_wmask, bus.resp_valid,
               bus.resp_rdata, bus.resp_err);
    end
    release_resp();
  endtask

  task automatic test_errors();
    send(1'b0, LBU, 64'h8000_0005, 64'd0, 64'h0000_9A00_0000_0000);
    @(posedge clk);
    #1;
    release_resp();
    send(1'b0, LW, 64'h8000_0002, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++;
    if (bus.mem_read !== 1'b0 || bus.resp_valid !== 1'b1 ||
        bus.resp_err !== 1'b1 || bus.resp_rdata !== 64'd0) begin
      errors++;
      $display("FAIL lw_misal rd=%b v=%b e=%b d=%h want 0 1 1 0",
               bus.mem_read, bus.resp_valid, bus.resp_err, bus.resp_rdata);
    end
    release_resp();
    send(1'b0, 3'b111, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++;
    if (bus.mem_read !== 1'b0 || bus.resp_valid !== 1'b1 ||
        bus.resp_err !== 1'b1 || bus.resp_rdata !== 64'd0) begin
      errors++;
      $display("FAIL ld_f3_111 rd=%b v=%b e=%b d=%h want 0 1 1 0",
               bus.mem_read, bus.resp_valid, bus.resp_err, bus.resp_rdata);
    end
    release_resp();
    send(1'b1, 3'b100, 64'h8000_0000, 64'h55, 64'd0);
    checks++;
    if (bus.mem_write !== 1'b0 || bus.resp_err !== 1'b1 ||
        bus.resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL st_f3_1xx wr=%b e=%b v=%b want 0 1 1",
               bus.mem_write, bus.resp_err, bus.resp_valid);
    end
    release_resp();
  endtask

  task automatic test_backpressure();
    send(1'b0, LW, 64'h8000_0008, 64'd0, 64'h0000_0000_8000_0001);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
          bus.resp_rdata !== 64'hFFFF_FFFF_8000_0001 ||
          bus.resp_err !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d v=%b r=%b d=%h e=%b want 1 0 ffffffff80000001 0",
                 i, bus.resp_valid, bus.req_ready,
                 bus.resp_rdata, bus.resp_err);
      end
    end
    release_resp();
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release v=%b r=%b want 0 1",
               bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid();
    send(1'b1, SD, 64'h8000_0200, 64'hDEAD_BEEF_CAFE_F00D, 64'd0);
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_wmask !== 8'hFF) begin
      errors++;
      $display("FAIL sd_access wr=%b m=%h want 1 ff",
               bus.mem_write, bus.mem_wmask);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_write !== 1'b0 || bus.req_ready !== 1'b1 ||
        bus.resp_valid !== 1'b0 || bus.mem_wmask !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid wr=%b r=%b v=%b m=%h want 0 1 0 00",
               bus.mem_write, bus.req_ready, bus.resp_valid,
               bus.mem_wmask);
    end
    @(negedge clk);
    rst = 1'b0;
    send(1'b0, LD, 64'h8000_0018, 64'd0, 64'h0102_0304_0506_0708);
    @(posedge clk);
    #1;
    checks++;
    if (bus.resp_valid !== 1'b1 ||
        bus.resp_rdata !== 64'h0102_0304_0506_0708 ||
        bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_next_ld v=%b d=%h e=%b want 1 0102030405060708 0",
               bus.resp_valid, bus.resp_rdata, bus.resp_err);
    end
    release_resp();
  endtask

  initial begin
    test_reset();
    test_ld();
    test_lb_lbu();
    test_lh_lw();
    test_sh();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
